micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer_pkg.sv | 30 +++
 rtl/micro_sequencer_stack.sv | 46 ++++
 rtl/micro_sequencer.sv | 136 +++++++++++++
 tb/tb_micro_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer: sequencing opcodes and the
// layout of a micro-word {next_addr, seq, ctrl}.
package micro_sequencer_pkg;

    localparam int SEQ_W = 3;

    typedef enum logic [SEQ_W-1:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_JZ       = 3'd1,
        SEQ_JN       = 3'd2,
        SEQ_DISPATCH = 3'd3,
        SEQ_CALL     = 3'd4,
        SEQ_RET      = 3'd5,
        SEQ_HALT     = 3'd6,
        SEQ_RSVD     = 3'd7
    } seq_e;

    function automatic int seq_lsb(input int ctrl_w);
        return ctrl_w;
    endfunction

    function automatic int na_lsb(input int ctrl_w);
        return ctrl_w + SEQ_W;
    endfunction

    function automatic int word_w(input int addr_w, input int ctrl_w);
        return addr_w + SEQ_W + ctrl_w;
    endfunction

endpackage

// File: rtl/micro_sequencer_stack.sv
// Return-address LIFO for micro-calls; push is ignored when full and pop
// when empty, so the caller only needs to look at full/empty for errors.
module micro_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_m1;

    assign count_m1 = count - CNT_W'(1);
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign top      = mem[count_m1[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count_m1;
        end
    end

    // Entries need no reset: an empty stack never exposes them.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: writable control store, registered MIR, next-address
// selection with branch/dispatch/call/return, and halt/error latching.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int CTRL_W      = 12,
    parameter int OPC_W       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_VEC   = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                stall,
    input  logic                                flag_z,
    input  logic                                flag_n,
    input  logic [OPC_W-1:0]                    opcode,
    input  logic                                cs_we,
    input  logic [ADDR_W-1:0]                   cs_waddr,
    input  logic [word_w(ADDR_W, CTRL_W)-1:0]   cs_wdata,
    output logic [CTRL_W-1:0]                   ctrl,
    output logic [ADDR_W-1:0]                   upc,
    output logic                                halted,
    output logic                                err_ovf,
    output logic                                err_unf
);

    localparam int WORD_W  = word_w(ADDR_W, CTRL_W);
    localparam int SEQ_LSB = seq_lsb(CTRL_W);
    localparam int NA_LSB  = na_lsb(CTRL_W);
    localparam logic [WORD_W-1:0] RESET_MIR = {ADDR_W'(RESET_VEC), SEQ_NEXT, CTRL_W'(0)};

    logic [WORD_W-1:0] cs_mem [2**ADDR_W];
    logic [WORD_W-1:0] mir;

    seq_e              seq;
    logic [ADDR_W-1:0] na;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic              run;
    logic              do_fetch;
    logic              do_push;
    logic              do_pop;
    logic              set_halt;
    logic              set_ovf;
    logic              set_unf;

    assign ctrl    = mir[CTRL_W-1:0];
    assign upc_inc = upc + ADDR_W'(1);
    assign run     = !stall && !halted;

    // Writes are independent of reset, stall and halt; a same-cycle fetch of
    // the written address sees the previous contents.
    always_ff @(posedge clk) begin
        if (cs_we) begin
            cs_mem[cs_waddr] <= cs_wdata;
        end
    end

    always_comb begin
        seq      = seq_e'(mir[SEQ_LSB +: SEQ_W]);
        na       = mir[NA_LSB +: ADDR_W];
        target   = na;
        do_fetch = 1'b1;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        set_halt = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        case (seq)
            SEQ_JZ:       target = na | ADDR_W'(flag_z);
            SEQ_JN:       target = na | ADDR_W'(flag_n);
            SEQ_DISPATCH: target = na | ADDR_W'(opcode);
            SEQ_CALL: begin
                if (stk_full) begin
                    do_fetch = 1'b0;
                    set_halt = 1'b1;
                    set_ovf  = 1'b1;
                end else begin
                    do_push = 1'b1;
                end
            end
            SEQ_RET: begin
                if (stk_empty) begin
                    do_fetch = 1'b0;
                    set_halt = 1'b1;
                    set_unf  = 1'b1;
                end else begin
                    target = stk_top;
                    do_pop = 1'b1;
                end
            end
            SEQ_HALT: begin
                do_fetch = 1'b0;
                set_halt = 1'b1;
            end
            default: target = na;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mir     <= RESET_MIR;
            upc     <= ADDR_W'(RESET_VEC);
            halted  <= 1'b0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (run) begin
            if (do_fetch) begin
                mir <= cs_mem[target];
                upc <= target;
            end
            if (set_halt) halted  <= 1'b1;
            if (set_ovf)  err_ovf <= 1'b1;
            if (set_unf)  err_unf <= 1'b1;
        end
    end

    micro_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (run && do_push),
        .pop       (run && do_pop),
        .push_data (upc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: loads small microprograms and
// scores upc/ctrl/halted/errors cycle by cycle against hand-derived values.
module tb_micro_sequencer;
    import micro_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flag_z;
    logic        flag_n;
    logic [7:0]  opcode;
    logic        cs_we;
    logic [8:0]  cs_waddr;
    logic [23:0] cs_wdata;
    logic [11:0] ctrl;
    logic [8:0]  upc;
    logic        halted;
    logic        err_ovf;
    logic        err_unf;

    always #5 clk = ~clk;

    micro_sequencer #(
        .ADDR_W      (9),
        .CTRL_W      (12),
        .OPC_W       (8),
        .STACK_DEPTH (4),
        .RESET_VEC   (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .opcode   (opcode),
        .cs_we    (cs_we),
        .cs_waddr (cs_waddr),
        .cs_wdata (cs_wdata),
        .ctrl     (ctrl),
        .upc      (upc),
        .halted   (halted),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf)
    );

    typedef struct {
        string       tag;
        logic [8:0]  upc;
        logic [11:0] ctrl;
        logic        h;
        logic        o;
        logic        u;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cs_write(input int a, input int na, input seq_e s, input int c);
        cs_we    = 1'b1;
        cs_waddr = 9'(a);
        cs_wdata = {9'(na), s, 12'(c)};
        step();
        cs_we    = 1'b0;
    endtask

    task automatic begin_reset();
        rst_n  = 1'b0;
        stall  = 1'b0;
        flag_z = 1'b0;
        flag_n = 1'b0;
        opcode = '0;
        cs_we  = 1'b0;
    endtask

    task automatic cycle(input string tag, input logic st, input int eu, input int ec,
                         input logic eh, input logic eo, input logic eun);
        exp_t e;
        exp_t got_e;
        stall  = st;
        e.tag  = tag;
        e.upc  = 9'(eu);
        e.ctrl = 12'(ec);
        e.h    = eh;
        e.o    = eo;
        e.u    = eun;
        sb.push_back(e);
        step();
        got_e = sb.pop_front();
        check_val({got_e.tag, ".upc"},    32'(upc),     32'(got_e.upc));
        check_val({got_e.tag, ".ctrl"},   32'(ctrl),    32'(got_e.ctrl));
        check_val({got_e.tag, ".halted"}, 32'(halted),  32'(got_e.h));
        check_val({got_e.tag, ".ovf"},    32'(err_ovf), 32'(got_e.o));
        check_val({got_e.tag, ".unf"},    32'(err_unf), 32'(got_e.u));
    endtask

    task automatic run_branch(input string tag, input seq_e s, input logic fz, input logic fn,
                              input int tgt);
        begin_reset();
        cs_write(0, 'h020, s, 'h002);
        cs_write('h020, 0, SEQ_HALT, 'h320);
        cs_write('h021, 0, SEQ_HALT, 'h321);
        cycle({tag, ".rst"}, 0, 0, 0, 0, 0, 0);
        flag_z = fz;
        flag_n = fn;
        rst_n  = 1'b1;
        cycle({tag, ".c1"}, 0, 0, 'h002, 0, 0, 0);
        cycle({tag, ".c2"}, 0, tgt, tgt + 'h300, 0, 0, 0);
        cycle({tag, ".c3"}, 0, tgt, tgt + 'h300, 1, 0, 0);
    endtask

    initial begin
        begin_reset();
        cs_waddr = '0;
        cs_wdata = '0;

        // Straight-line program ending in HALT, then hold halted.
        cs_write(0, 5, SEQ_NEXT, 'h001);
        cs_write(5, 0, SEQ_HALT, 'h0AA);
        cycle("halt.rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle("halt.c1", 0, 0, 'h001, 0, 0, 0);
        cycle("halt.c2", 0, 5, 'h0AA, 0, 0, 0);
        for (int i = 0; i < 11; i++) cycle("halt.hold", 0, 5, 'h0AA, 1, 0, 0);

        run_branch("jz1", SEQ_JZ, 1, 0, 'h021);
        run_branch("jz0", SEQ_JZ, 0, 1, 'h020);
        run_branch("jn1", SEQ_JN, 0, 1, 'h021);
        run_branch("jn0", SEQ_JN, 1, 0, 'h020);

        // Opcode dispatch.
        begin_reset();
        cs_write(0, 'h100, SEQ_DISPATCH, 'h003);
        cs_write('h117, 0, SEQ_HALT, 'h117);
        cycle("disp.rst", 0, 0, 0, 0, 0, 0);
        opcode = 8'h17;
        flag_z = 1'b1;
        rst_n  = 1'b1;
        cycle("disp.c1", 0, 0, 'h003, 0, 0, 0);
        cycle("disp.c2", 0, 'h117, 'h117, 0, 0, 0);
        cycle("disp.c3", 0, 'h117, 'h117, 1, 0, 0);

        // CALL/RET with a 3-cycle stall right after the CALL word is fetched.
        begin_reset();
        cs_write(0, 'h010, SEQ_NEXT, 'h004);
        cs_write('h010, 'h040, SEQ_CALL, 'h010);
        cs_write('h040, 0, SEQ_RET, 'h040);
        cs_write('h011, 0, SEQ_HALT, 'h011);
        cycle("call.rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle("call.c1", 0, 0, 'h004, 0, 0, 0);
        cycle("call.c2", 0, 'h010, 'h010, 0, 0, 0);
        flag_z = 1'b1;
        opcode = 8'hFF;
        for (int i = 0; i < 3; i++) cycle("call.stall", 1, 'h010, 'h010, 0, 0, 0);
        cycle("call.c3", 0, 'h040, 'h040, 0, 0, 0);
        cycle("call.c4", 0, 'h011, 'h011, 0, 0, 0);
        cycle("call.c5", 0, 'h011, 'h011, 1, 0, 0);

        // Return address wraps past the top of the control store.
        begin_reset();
        cs_write(0, 'h1FF, SEQ_NEXT, 'h001);
        cs_write('h1FF, 'h040, SEQ_CALL, 'h1FF);
        cs_write('h040, 0, SEQ_RET, 'h040);
        cycle("wrap.rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle("wrap.c1", 0, 0, 'h001, 0, 0, 0);
        cycle("wrap.c2", 0, 'h1FF, 'h1FF, 0, 0, 0);
        cycle("wrap.c3", 0, 'h040, 'h040, 0, 0, 0);
        cycle("wrap.c4", 0, 0, 'h001, 0, 0, 0);
        cycle("wrap.c5", 0, 'h1FF, 'h1FF, 0, 0, 0);

        // Five nested calls overflow a 4-deep stack; then reset recovers.
        begin_reset();
        for (int i = 0; i < 5; i++) cs_write(i, i + 1, SEQ_CALL, 'h0C0 + i);
        cycle("ovf.rst", 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            rst_n = 1'b1;
            for (int i = 0; i < 5; i++) cycle("ovf.run", 0, i, 'h0C0 + i, 0, 0, 0);
            cycle("ovf.trip", 0, 4, 'h0C4, 1, 1, 0);
            cycle("ovf.hold", 0, 4, 'h0C4, 1, 1, 0);
            rst_n = 1'b0;
            cycle("ovf.reset", 1, 0, 0, 0, 0, 0);
        end

        // RET with empty stack at the reset vector.
        begin_reset();
        cs_write(0, 0, SEQ_RET, 'h055);
        cycle("unf.rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle("unf.c1", 0, 0, 'h055, 0, 0, 0);
        cycle("unf.c2", 0, 0, 'h055, 1, 0, 1);
        cycle("unf.c3", 0, 0, 'h055, 1, 0, 1);

        // Write to the address being fetched: MIR gets the old word.
        begin_reset();
        cs_write(0, 0, SEQ_HALT, 'h0A1);
        cycle("rdw.rst", 0, 0, 0, 0, 0, 0);
        rst_n    = 1'b1;
        cs_we    = 1'b1;
        cs_waddr = 9'h000;
        cs_wdata = {9'h000, SEQ_HALT, 12'h0B2};
        cycle("rdw.c1", 0, 0, 'h0A1, 0, 0, 0);
        cs_we = 1'b0;
        cycle("rdw.c2", 0, 0, 'h0A1, 1, 0, 0);
        rst_n = 1'b0;
        cycle("rdw.rst2", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle("rdw.new", 0, 0, 'h0B2, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
